image_mode_ctrl: RTL and testbench
==================================

# image_mode_ctrl

Frame-synchronous controller for the `image_mode` configuration byte consumed by the pixel processing stages (negative, etc.). It arbitrates mode-change requests from a host register port, a front-panel step key and an internal demo auto-cycler. The winning request is held as pending and committed to `image_mode_o` only at the vsync falling edge. Downstream stages therefore see a stable value before they latch `image_mode_i` on their own vsync rising edge, and a frame is never processed under a mixed mode.

## Interface
Parameters:
- `MODE_MAX`, 8'd7: highest legal mode; legal range is 0..MODE_MAX.
- `RESET_MODE`, 8'd0: value of `image_mode_o` after reset; must be ≤ MODE_MAX.

Ports:
- `clock`  in  1  pixel clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `vs_i`  in  1  vsync, same timing as the datapath `vs_i`.
- `host_req_i`  in  1  one-cycle strobe requesting mode `host_mode_i`.
- `host_mode_i`  in  8  requested mode; sampled when `host_req_i`=1.
- `host_ack_o`  out  1  one-cycle pulse: host request accepted.
- `host_err_o`  out  1  one-cycle pulse: host request rejected because the mode exceeds MODE_MAX.
- `key_step_i`  in  1  one-cycle strobe, already debounced; requests a step to the next mode.
- `demo_en_i`  in  1  enables the demo auto-cycle.
- `demo_frames_i`  in  8  frames per demo step; 0 is treated as 1.
- `image_mode_o`  out  8  committed mode; drives `image_mode_i` of the processing stages.
- `pending_o`  out  1  a pending mode is awaiting commit.
- `mode_changed_o`  out  1  one-cycle pulse when a commit changes `image_mode_o`.

## Operation
- State machine: IDLE (no pending value) and PEND (pending register `pmode` valid).
- Edge detect: register `vs_d <= vs_i`. The frame edge `fe` is `vs_d & ~vs_i`, i.e. the vsync falling edge.
- Request arbitration per cycle, fixed priority: host > key > demo. Lower-priority requests in the same cycle are dropped, not queued.
- Host request:
  - Legal mode (`host_mode_i` ≤ MODE_MAX): `pmode <= host_mode_i`, state goes to PEND, `host_ack_o` is pulsed.
  - Illegal mode: `host_err_o` is pulsed. State and `pmode` are unchanged.
- Key or demo step:
  - The base value is `pmode` in PEND, otherwise `image_mode_o`.
  - The step computes base+1, wrapping MODE_MAX→0. Result goes to `pmode`, state goes to PEND.
- Commit: on `fe` with state PEND:
  - `image_mode_o <= pmode`, state goes to IDLE.
  - `mode_changed_o` pulses only if `pmode` differs from the old `image_mode_o`.
  - `fe` in IDLE does nothing.
- Request in the same cycle as `fe`: the commit uses `pmode` as it was before that cycle. The new request then loads `pmode` and the state stays or goes to PEND, for commit on the next `fe`. A key or demo step in that cycle uses the pre-commit `pmode` as its base.
- Demo counter `fcnt` (8 bits):
  - Cleared while `demo_en_i`=0, and on any accepted host or key request.
  - Otherwise increments on each `fe`.
  - When the incremented value reaches max(`demo_frames_i`,1), `fcnt` returns to 0 and a demo step is raised on the next cycle. That cycle is not an `fe`, so the step is committed at the following `fe`.
- Width rule: all mode arithmetic is 8-bit; the wrap compare is against MODE_MAX, not 255.

## Timing
- Reset values:
  - `image_mode_o`=RESET_MODE.
  - `pending_o`, `host_ack_o`, `host_err_o`, `mode_changed_o` = 0.
  - `vs_d`=0, `fcnt`=0, state=IDLE.
- `host_ack_o` and `host_err_o` are registered and assert the cycle after `host_req_i`.
- `pending_o` rises the cycle after acceptance and falls the cycle after the commit `fe`.
- `image_mode_o` and `mode_changed_o` update the cycle after `fe` is detected (one cycle after `vs_i` falls as sampled).
- Latency from request to visible mode is up to one frame plus 1 cycle.
- Reset mid-frame discards any pending value; no commit occurs before the next `fe` after reset release.
- `host_req_i` held for several cycles is treated as that many independent requests, each acked.

## Test plan
- Reset, then legal host request: `host_mode_i`=1 with one-cycle req → ack next cycle, `pending_o`=1, `image_mode_o` stays 0 until the vs falling edge, then becomes 1 with a `mode_changed_o` pulse.
- Illegal host request: `host_mode_i`=9 with MODE_MAX=7 → `host_err_o` pulse, no ack, `pending_o`=0, `image_mode_o` unchanged across 2 frames.
- Key wrap: `image_mode_o`=7, then 2 key strobes in one frame → pending goes 0 then 1; commit gives 1.
- Simultaneous requests: host mode 3 and key in the same cycle → only the host is applied, commit gives 3. A host request coinciding with `fe` (pending 5) → commit 5, then 3 on the next frame.
- Demo: `demo_en_i`=1, `demo_frames_i`=2, start mode 0 → mode steps 0→1→2 every 2 frames. `demo_frames_i`=0 steps every frame. Dropping `demo_en_i` stops stepping.
- Reset asserted while PEND (pmode=4) → after release `image_mode_o`=RESET_MODE and no commit on the next `fe`.

Source files
------------

// File: rtl/image_mode_ctrl.sv
// Holds the image_mode byte stable per frame: arbitrates host/key/demo requests into a pending
// value that is committed only on the vsync falling edge.
module image_mode_ctrl #(
  parameter logic [7:0] MODE_MAX   = 8'd7,
  parameter logic [7:0] RESET_MODE = 8'd0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       vs_i,
  input  logic       host_req_i,
  input  logic [7:0] host_mode_i,
  output logic       host_ack_o,
  output logic       host_err_o,
  input  logic       key_step_i,
  input  logic       demo_en_i,
  input  logic [7:0] demo_frames_i,
  output logic [7:0] image_mode_o,
  output logic       pending_o,
  output logic       mode_changed_o
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pmode, w_pmode_nxt;
  logic [7:0] r_mode, w_mode_nxt;
  logic [7:0] r_fcnt, w_fcnt_nxt;
  logic       r_vs_d, r_demo_req, w_demo_req_nxt;
  logic       r_ack, r_err, r_chg, w_chg_nxt;

  logic       w_fe, w_host_ok, w_host_bad, w_key, w_demo, w_step;
  logic [7:0] w_base, w_step_mode, w_limit, w_fcnt_inc;

  assign w_fe        = r_vs_d & ~vs_i;
  assign w_host_ok   = host_req_i & (host_mode_i <= MODE_MAX);
  assign w_host_bad  = host_req_i & (host_mode_i > MODE_MAX);
  // Any host strobe, legal or not, wins the cycle and drops key/demo.
  assign w_key       = ~host_req_i & key_step_i;
  assign w_demo      = ~host_req_i & ~key_step_i & r_demo_req & demo_en_i;
  assign w_step      = w_key | w_demo;
  assign w_base      = (r_state == PEND) ? r_pmode : r_mode;
  assign w_step_mode = (w_base >= MODE_MAX) ? 8'd0 : w_base + 8'd1;
  assign w_limit     = (demo_frames_i == 8'd0) ? 8'd1 : demo_frames_i;
  assign w_fcnt_inc  = r_fcnt + 8'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_pmode_nxt    = r_pmode;
    w_mode_nxt     = r_mode;
    w_chg_nxt      = 1'b0;
    w_fcnt_nxt     = r_fcnt;
    w_demo_req_nxt = 1'b0;

    if (r_state == PEND && w_fe) begin
      w_mode_nxt  = r_pmode;
      w_chg_nxt   = (r_pmode != r_mode);
      w_state_nxt = IDLE;
    end

    // A request coinciding with the commit reloads pending for the next frame.
    if (w_host_ok) begin
      w_pmode_nxt = host_mode_i;
      w_state_nxt = PEND;
    end else if (w_step) begin
      w_pmode_nxt = w_step_mode;
      w_state_nxt = PEND;
    end

    if (!demo_en_i || w_host_ok || w_key) begin
      w_fcnt_nxt = 8'd0;
    end else if (w_fe) begin
      if (w_fcnt_inc >= w_limit) begin
        w_fcnt_nxt     = 8'd0;
        w_demo_req_nxt = 1'b1;
      end else begin
        w_fcnt_nxt = w_fcnt_inc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_pmode    <= 8'd0;
      r_mode     <= RESET_MODE;
      r_fcnt     <= 8'd0;
      r_vs_d     <= 1'b0;
      r_demo_req <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_chg      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pmode    <= w_pmode_nxt;
      r_mode     <= w_mode_nxt;
      r_fcnt     <= w_fcnt_nxt;
      r_vs_d     <= vs_i;
      r_demo_req <= w_demo_req_nxt;
      r_ack      <= w_host_ok;
      r_err      <= w_host_bad;
      r_chg      <= w_chg_nxt;
    end
  end

  assign host_ack_o     = r_ack;
  assign host_err_o     = r_err;
  assign image_mode_o   = r_mode;
  assign pending_o      = (r_state == PEND);
  assign mode_changed_o = r_chg;

endmodule

// File: tb/tb_image_mode_ctrl.sv
// Directed scenarios plus randomized traffic, checked every cycle against a frame-level reference model.
module tb_image_mode_ctrl;

  localparam int MAXM = 7;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       vs_i = 1'b0;
  logic       host_req_i = 1'b0;
  logic [7:0] host_mode_i = 8'd0;
  logic       host_ack_o, host_err_o;
  logic       key_step_i = 1'b0;
  logic       demo_en_i = 1'b0;
  logic [7:0] demo_frames_i = 8'd1;
  logic [7:0] image_mode_o;
  logic       pending_o, mode_changed_o;

  int n_checks = 0;
  int n_fail = 0;

  image_mode_ctrl #(.MODE_MAX(8'd7), .RESET_MODE(8'd0)) dut (
    .clock(clock), .reset_n(reset_n), .vs_i(vs_i),
    .host_req_i(host_req_i), .host_mode_i(host_mode_i),
    .host_ack_o(host_ack_o), .host_err_o(host_err_o),
    .key_step_i(key_step_i), .demo_en_i(demo_en_i), .demo_frames_i(demo_frames_i),
    .image_mode_o(image_mode_o), .pending_o(pending_o), .mode_changed_o(mode_changed_o)
  );

  always #5 clock = ~clock;

  // Reference model: committed mode, optional pending mode, demo frame count.
  int  m_mode, m_pmode, m_fcnt;
  bit  m_pend, m_prev_vs, m_demo_due;
  bit  exp_ack, exp_err, exp_chg;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_pmode = 0; m_fcnt = 0;
      m_pend = 0; m_prev_vs = 0; m_demo_due = 0;
      exp_ack = 0; exp_err = 0; exp_chg = 0;
    end else begin
      bit frame_edge, host_legal, key_win, demo_win, due;
      int start, lim;
      frame_edge = m_prev_vs && !vs_i;
      host_legal = host_req_i && (int'(host_mode_i) <= MAXM);
      key_win    = !host_req_i && key_step_i;
      demo_win   = !host_req_i && !key_step_i && m_demo_due && demo_en_i;
      start      = m_pend ? m_pmode : m_mode;
      exp_ack    = host_legal;
      exp_err    = host_req_i && !host_legal;
      exp_chg    = 0;
      if (frame_edge && m_pend) begin
        exp_chg = (m_pmode != m_mode);
        m_mode  = m_pmode;
        m_pend  = 0;
      end
      if (host_legal) begin
        m_pmode = host_mode_i; m_pend = 1;
      end else if (key_win || demo_win) begin
        m_pmode = (start + 1) % (MAXM + 1); m_pend = 1;
      end
      due = 0;
      lim = (demo_frames_i == 0) ? 1 : int'(demo_frames_i);
      if (!demo_en_i || host_legal || key_win) m_fcnt = 0;
      else if (frame_edge) begin
        m_fcnt = m_fcnt + 1;
        if (m_fcnt >= lim) begin m_fcnt = 0; due = 1; end
      end
      m_demo_due = due;
      m_prev_vs  = vs_i;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("host_ack", int'(host_ack_o), int'(exp_ack));
    check("host_err", int'(host_err_o), int'(exp_err));
    check("mode_changed", int'(mode_changed_o), int'(exp_chg));
    check("image_mode", int'(image_mode_o), m_mode);
    check("pending", int'(pending_o), int'(m_pend));
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frame();
    vs_i = 1'b1; ticks(2);
    vs_i = 1'b0; ticks(6);
  endtask

  task automatic host(input int m);
    host_req_i = 1'b1; host_mode_i = 8'(m); tick();
    host_req_i = 1'b0; tick();
  endtask

  task automatic key();
    key_step_i = 1'b1; tick();
    key_step_i = 1'b0; tick();
  endtask

  task automatic pin(input string name, input int want_mode, input int want_pend);
    check({name, "_mode"}, int'(image_mode_o), want_mode);
    check({name, "_pend"}, int'(pending_o), want_pend);
    check({name, "_model"}, m_mode, want_mode);
  endtask

  initial begin
    ticks(3);
    pin("reset", 0, 0);
    reset_n = 1'b1; tick();

    host(1);
    pin("host1_before_fe", 0, 1);
    frame();
    pin("host1_commit", 1, 0);

    host(9);
    frame(); frame();
    pin("host_illegal", 1, 0);

    host(7); frame();
    pin("host7", 7, 0);
    key(); key();
    frame();
    pin("key_wrap", 1, 0);

    host_req_i = 1'b1; host_mode_i = 8'd3; key_step_i = 1'b1; tick();
    host_req_i = 1'b0; key_step_i = 1'b0; tick();
    frame();
    pin("host_over_key", 3, 0);

    host(5);
    vs_i = 1'b1; ticks(2);
    vs_i = 1'b0; host_req_i = 1'b1; host_mode_i = 8'd3; tick();
    host_req_i = 1'b0; tick();
    pin("host_at_fe", 5, 1);
    frame();
    pin("host_after_fe", 3, 0);

    host(0); frame();
    demo_en_i = 1'b1; demo_frames_i = 8'd2;
    frame(); frame(); frame();
    pin("demo2_a", 1, 0);
    frame(); frame();
    pin("demo2_b", 2, 0);
    demo_en_i = 1'b0; tick();
    demo_frames_i = 8'd0; demo_en_i = 1'b1;
    frame(); frame(); frame();
    pin("demo0", 4, 1);
    demo_en_i = 1'b0;
    frame(); frame();
    pin("demo_off", 5, 0);

    host(4);
    reset_n = 1'b0; tick();
    reset_n = 1'b1; tick();
    pin("reset_pend", 0, 0);
    frame();
    pin("reset_no_commit", 0, 0);

    for (int c = 0; c < 3000; c++) begin
      vs_i       = ((c % 16) < 3);
      host_req_i = ($urandom_range(0, 7) == 0);
      host_mode_i = 8'($urandom_range(0, 10));
      key_step_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) begin
        demo_en_i = 1'b0;
        tick();
        demo_frames_i = 8'($urandom_range(0, 3));
        demo_en_i = ($urandom_range(0, 2) != 0);
      end
      reset_n = ($urandom_range(0, 499) != 0);
      tick();
      reset_n = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
